// File: rtl/multicycle_sequencer_if.sv
// Decode-side handshake bundle between the control unit, datapath and the multicycle sequencer.
// The master drives the decoded instruction and interrupt request; the slave (sequencer) drives the datapath controls.
interface multicycle_sequencer_if;
    logic [15:0] ctrl_in;
    logic        instr_valid;
    logic        int_req;
    logic        stall_fetch;
    logic        flush;
    logic        imm_fetch;
    logic [1:0]  stack_op;
    logic [1:0]  stack_sel;
    logic        flags_restore;
    logic        pc_load;
    logic [1:0]  pc_src;
    logic        int_ack;
    logic        busy;

    modport master (
        output ctrl_in, instr_valid, int_req,
        input  stall_fetch, flush, imm_fetch, stack_op, stack_sel,
               flags_restore, pc_load, pc_src, int_ack, busy
    );

    modport slave (
        input  ctrl_in, instr_valid, int_req,
        output stall_fetch, flush, imm_fetch, stack_op, stack_sel,
               flags_restore, pc_load, pc_src, int_ack, busy
    );
endinterface

// File: rtl/multicycle_sequencer.sv
// Sequences CALL/RET/RTI stack traffic, two-word operand fetch and interrupt entry beside decode.
// IDLE outputs are Mealy on the decoded word; every other state is Moore.
module multicycle_sequencer #(
    parameter int PC_WORDS = 2
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    multicycle_sequencer_if.slave bus
);
    typedef enum logic [2:0] {
        S_IDLE, S_EXT, S_PUSH_PC, S_PUSH_FL, S_POP_FL, S_POP_PC, S_LOAD
    } state_t;

    typedef enum logic [1:0] {K_INT, K_CALL, K_RET} kind_t;

    localparam logic [1:0] LAST = 2'(PC_WORDS - 1);

    state_t     r_state, w_state_nxt;
    kind_t      r_kind, w_kind_nxt;
    logic [1:0] r_cnt, w_cnt_nxt;
    logic       r_int_pending;

    logic w_ldm, w_std, w_jmp, w_ret, w_rti, w_ldd, w_call, w_ext;
    logic w_int_svc, w_ack;

    logic       w_stall_fetch, w_flush, w_imm_fetch, w_flags_restore;
    logic       w_pc_load, w_int_ack, w_busy;
    logic [1:0] w_stack_op, w_stack_sel, w_pc_src;

    assign w_ldm  = bus.ctrl_in[14];
    assign w_std  = bus.ctrl_in[12];
    assign w_jmp  = bus.ctrl_in[11];
    assign w_ret  = bus.ctrl_in[8];
    assign w_rti  = bus.ctrl_in[7];
    assign w_ldd  = bus.ctrl_in[6];
    assign w_call = bus.ctrl_in[3];
    assign w_ext  = w_ldm | w_ldd | w_std;

    // A request arriving in the same IDLE cycle wins over the instruction in decode.
    assign w_int_svc = r_int_pending | bus.int_req;
    assign w_ack     = (r_state == S_LOAD) && (r_kind == K_INT);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state       <= S_IDLE;
            r_kind        <= K_CALL;
            r_cnt         <= 2'd0;
            r_int_pending <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_kind        <= w_kind_nxt;
            r_cnt         <= w_cnt_nxt;
            r_int_pending <= w_ack ? 1'b0 : (r_int_pending | bus.int_req);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_kind_nxt  = r_kind;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            S_IDLE: begin
                w_cnt_nxt = 2'd0;
                if (w_int_svc) begin
                    w_state_nxt = S_PUSH_PC;
                    w_kind_nxt  = K_INT;
                end else if (bus.instr_valid) begin
                    if (w_rti) begin
                        w_state_nxt = S_POP_FL;
                        w_kind_nxt  = K_RET;
                    end else if (w_ret) begin
                        w_state_nxt = S_POP_PC;
                        w_kind_nxt  = K_RET;
                    end else if (w_call) begin
                        w_state_nxt = S_PUSH_PC;
                        w_kind_nxt  = K_CALL;
                    end else if (w_ext) begin
                        w_state_nxt = S_EXT;
                    end
                end
            end
            S_EXT:     w_state_nxt = S_IDLE;
            S_PUSH_PC: begin
                if (r_cnt == LAST) begin
                    w_cnt_nxt   = 2'd0;
                    w_state_nxt = (r_kind == K_INT) ? S_PUSH_FL : S_LOAD;
                end else begin
                    w_cnt_nxt = r_cnt + 2'd1;
                end
            end
            S_PUSH_FL: w_state_nxt = S_LOAD;
            S_POP_FL: begin
                w_cnt_nxt   = 2'd0;
                w_state_nxt = S_POP_PC;
            end
            S_POP_PC: begin
                if (r_cnt == LAST) begin
                    w_cnt_nxt   = 2'd0;
                    w_state_nxt = S_LOAD;
                end else begin
                    w_cnt_nxt = r_cnt + 2'd1;
                end
            end
            S_LOAD:    w_state_nxt = S_IDLE;
            default:   w_state_nxt = S_IDLE;
        endcase
    end

    // Outputs are forced low while reset is held so the Mealy IDLE path cannot leak through.
    always_comb begin
        w_stall_fetch   = 1'b0;
        w_flush         = 1'b0;
        w_imm_fetch     = 1'b0;
        w_stack_op      = 2'b00;
        w_stack_sel     = 2'b00;
        w_flags_restore = 1'b0;
        w_pc_load       = 1'b0;
        w_pc_src        = 2'b00;
        w_int_ack       = 1'b0;
        w_busy          = 1'b0;
        if (i_rst_n) begin
            w_busy = (r_state != S_IDLE);
            case (r_state)
                S_IDLE: begin
                    if (w_int_svc) begin
                        w_flush       = 1'b1;
                        w_stall_fetch = 1'b1;
                    end else if (bus.instr_valid) begin
                        if (w_rti || w_ret || w_call) begin
                            w_stall_fetch = 1'b1;
                        end else if (!w_ext && w_jmp) begin
                            w_pc_load = 1'b1;
                            w_pc_src  = 2'b11;
                            w_flush   = 1'b1;
                        end
                    end
                end
                S_EXT: begin
                    w_imm_fetch = 1'b1;
                    w_flush     = 1'b1;
                end
                S_PUSH_PC: begin
                    w_stack_op    = 2'b01;
                    w_stack_sel   = r_cnt;
                    w_stall_fetch = 1'b1;
                end
                S_PUSH_FL: begin
                    w_stack_op    = 2'b01;
                    w_stack_sel   = 2'b10;
                    w_stall_fetch = 1'b1;
                end
                S_POP_FL: begin
                    w_stack_op      = 2'b10;
                    w_stack_sel     = 2'b10;
                    w_flags_restore = 1'b1;
                    w_stall_fetch   = 1'b1;
                end
                S_POP_PC: begin
                    w_stack_op    = 2'b10;
                    w_stack_sel   = LAST - r_cnt;
                    w_stall_fetch = 1'b1;
                end
                S_LOAD: begin
                    w_pc_load = 1'b1;
                    w_flush   = 1'b1;
                    case (r_kind)
                        K_INT:   begin w_pc_src = 2'b10; w_int_ack = 1'b1; end
                        K_CALL:  w_pc_src = 2'b11;
                        default: w_pc_src = 2'b01;
                    endcase
                end
                default: ;
            endcase
        end
    end

    assign bus.stall_fetch   = w_stall_fetch;
    assign bus.flush         = w_flush;
    assign bus.imm_fetch     = w_imm_fetch;
    assign bus.stack_op      = w_stack_op;
    assign bus.stack_sel     = w_stack_sel;
    assign bus.flags_restore = w_flags_restore;
    assign bus.pc_load       = w_pc_load;
    assign bus.pc_src        = w_pc_src;
    assign bus.int_ack       = w_int_ack;
    assign bus.busy          = w_busy;
endmodule

// File: tb/tb_multicycle_sequencer.sv
// Scoreboarded bench for multicycle_sequencer: each scenario queues per-cycle expected outputs
// alongside its stimulus and compares them against the DUT at the falling edge.
module tb_multicycle_sequencer;
    typedef struct packed {
        logic [15:0] ctrl;
        logic        vld;
        logic        irq;
    } stim_t;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;
    logic [13:0] sb[$];

    multicycle_sequencer_if bus();

    multicycle_sequencer #(.PC_WORDS(2)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    // {stall, flush, imm, stack_op, stack_sel, flags_restore, pc_load, pc_src, int_ack, busy}
    logic [13:0] obs;
    assign obs = {bus.stall_fetch, bus.flush, bus.imm_fetch, bus.stack_op, bus.stack_sel,
                  bus.flags_restore, bus.pc_load, bus.pc_src, bus.int_ack, bus.busy};

    function automatic logic [13:0] ov(input logic st, input logic fl, input logic im,
                                       input logic [1:0] op, input logic [1:0] sel,
                                       input logic fr, input logic pl, input logic [1:0] src,
                                       input logic ack, input logic bz);
        return {st, fl, im, op, sel, fr, pl, src, ack, bz};
    endfunction

    function automatic stim_t S(input logic [15:0] c, input logic v, input logic q);
        return '{ctrl: c, vld: v, irq: q};
    endfunction

    localparam logic [13:0] ZERO = 14'd0;

    task automatic drive(input stim_t s);
        bus.ctrl_in     = s.ctrl;
        bus.instr_valid = s.vld;
        bus.int_req     = s.irq;
    endtask

    task automatic test_reset;
        drive(S(16'h0008, 1'b1, 1'b1));
        rst_n = 1'b0;
        #1;
        sb.push_back(ZERO);
        @(negedge clk);
        checks++;
        if (obs !== sb[0]) begin errors++; $display("FAIL reset_hold got=%h exp=%h", obs, sb[0]); end
        void'(sb.pop_front());
        drive(S(16'h0000, 1'b0, 1'b0));
        @(posedge clk); #1;
        rst_n = 1'b1;
        sb.push_back(ZERO);
        @(negedge clk);
        checks++;
        if (obs !== sb[0]) begin errors++; $display("FAIL reset_idle got=%h exp=%h", obs, sb[0]); end
        void'(sb.pop_front());
        @(posedge clk); #1;
    endtask

    task automatic test_call;
        stim_t st[$];
        logic [13:0] e;
        st.push_back(S(16'h0008, 1, 0)); sb.push_back(ov(1,0,0,2'b00,2'b00,0,0,2'b00,0,0));
        st.push_back(S(16'h0000, 0, 0)); sb.push_back(ov(1,0,0,2'b01,2'b00,0,0,2'b00,0,1));
        st.push_back(S(16'h0000, 0, 0)); sb.push_back(ov(1,0,0,2'b01,2'b01,0,0,2'b00,0,1));
        st.push_back(S(16'h0000, 0, 0)); sb.push_back(ov(0,1,0,2'b00,2'b00,0,1,2'b11,0,1));
        st.push_back(S(16'h0000, 0, 0)); sb.push_back(ZERO);
        foreach (st[i]) begin
            drive(st[i]);
            @(negedge clk);
            e = sb.pop_front();
            checks++;
            if (obs !== e) begin errors++; $display("FAIL call cyc%0d got=%h exp=%h", i, obs, e); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_rti;
        stim_t st[$];
        logic [13:0] e;
        // RET bit also set: RTI must take priority and restore flags first.
        st.push_back(S(16'h0180, 1, 0)); sb.push_back(ov(1,0,0,2'b00,2'b00,0,0,2'b00,0,0));
        st.push_back(S(16'h0000, 0, 0)); sb.push_back(ov(1,0,0,2'b10,2'b10,1,0,2'b00,0,1));
        st.push_back(S(16'h0000, 0, 0)); sb.push_back(ov(1,0,0,2'b10,2'b01,0,0,2'b00,0,1));
        st.push_back(S(16'h0000, 0, 0)); sb.push_back(ov(1,0,0,2'b10,2'b00,0,0,2'b00,0,1));
        st.push_back(S(16'h0000, 0, 0)); sb.push_back(ov(0,1,0,2'b00,2'b00,0,1,2'b01,0,1));
        st.push_back(S(16'h0000, 0, 0)); sb.push_back(ZERO);
        foreach (st[i]) begin
            drive(st[i]);
            @(negedge clk);
            e = sb.pop_front();
            checks++;
            if (obs !== e) begin errors++; $display("FAIL rti cyc%0d got=%h exp=%h", i, obs, e); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_ext_jmp;
        stim_t st[$];
        logic [13:0] e;
        logic [15:0] ops[3];
        ops[0] = 16'h4000; ops[1] = 16'h0040; ops[2] = 16'h1000;
        foreach (ops[k]) begin
            st.push_back(S(ops[k], 1, 0));   sb.push_back(ZERO);
            st.push_back(S(16'h0000, 0, 0)); sb.push_back(ov(0,1,1,2'b00,2'b00,0,0,2'b00,0,1));
            st.push_back(S(16'h0000, 0, 0)); sb.push_back(ZERO);
        end
        // JMP is a single Mealy cycle; an invalid slot next must stay quiet.
        st.push_back(S(16'h0800, 1, 0)); sb.push_back(ov(0,1,0,2'b00,2'b00,0,1,2'b11,0,0));
        st.push_back(S(16'h0808, 0, 0)); sb.push_back(ZERO);
        st.push_back(S(16'h0000, 0, 0)); sb.push_back(ZERO);
        foreach (st[i]) begin
            drive(st[i]);
            @(negedge clk);
            e = sb.pop_front();
            checks++;
            if (obs !== e) begin errors++; $display("FAIL ext_jmp cyc%0d got=%h exp=%h", i, obs, e); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_int_during_ret;
        stim_t st[$];
        logic [13:0] e;
        st.push_back(S(16'h0100, 1, 0)); sb.push_back(ov(1,0,0,2'b00,2'b00,0,0,2'b00,0,0));
        st.push_back(S(16'h0000, 0, 1)); sb.push_back(ov(1,0,0,2'b10,2'b01,0,0,2'b00,0,1));
        st.push_back(S(16'h0000, 0, 0)); sb.push_back(ov(1,0,0,2'b10,2'b00,0,0,2'b00,0,1));
        st.push_back(S(16'h0000, 0, 0)); sb.push_back(ov(0,1,0,2'b00,2'b00,0,1,2'b01,0,1));
        st.push_back(S(16'h0008, 1, 0)); sb.push_back(ov(1,1,0,2'b00,2'b00,0,0,2'b00,0,0));
        st.push_back(S(16'h0000, 0, 0)); sb.push_back(ov(1,0,0,2'b01,2'b00,0,0,2'b00,0,1));
        st.push_back(S(16'h0000, 0, 0)); sb.push_back(ov(1,0,0,2'b01,2'b01,0,0,2'b00,0,1));
        st.push_back(S(16'h0000, 0, 0)); sb.push_back(ov(1,0,0,2'b01,2'b10,0,0,2'b00,0,1));
        st.push_back(S(16'h0000, 0, 0)); sb.push_back(ov(0,1,0,2'b00,2'b00,0,1,2'b10,1,1));
        st.push_back(S(16'h0000, 0, 0)); sb.push_back(ZERO);
        foreach (st[i]) begin
            drive(st[i]);
            @(negedge clk);
            e = sb.pop_front();
            checks++;
            if (obs !== e) begin errors++; $display("FAIL int_ret cyc%0d got=%h exp=%h", i, obs, e); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_int_vs_call;
        stim_t st[$];
        logic [13:0] e;
        st.push_back(S(16'h0008, 1, 1)); sb.push_back(ov(1,1,0,2'b00,2'b00,0,0,2'b00,0,0));
        st.push_back(S(16'h0000, 0, 0)); sb.push_back(ov(1,0,0,2'b01,2'b00,0,0,2'b00,0,1));
        st.push_back(S(16'h0000, 0, 0)); sb.push_back(ov(1,0,0,2'b01,2'b01,0,0,2'b00,0,1));
        st.push_back(S(16'h0000, 0, 0)); sb.push_back(ov(1,0,0,2'b01,2'b10,0,0,2'b00,0,1));
        st.push_back(S(16'h0000, 0, 0)); sb.push_back(ov(0,1,0,2'b00,2'b00,0,1,2'b10,1,1));
        st.push_back(S(16'h0000, 0, 0)); sb.push_back(ZERO);
        st.push_back(S(16'h0000, 0, 0)); sb.push_back(ZERO);
        foreach (st[i]) begin
            drive(st[i]);
            @(negedge clk);
            e = sb.pop_front();
            checks++;
            if (obs !== e) begin errors++; $display("FAIL int_call cyc%0d got=%h exp=%h", i, obs, e); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset_mid_call;
        stim_t st[$];
        logic [13:0] e;
        st.push_back(S(16'h0008, 1, 0)); sb.push_back(ov(1,0,0,2'b00,2'b00,0,0,2'b00,0,0));
        st.push_back(S(16'h0008, 1, 0)); sb.push_back(ov(1,0,0,2'b01,2'b00,0,0,2'b00,0,1));
        st.push_back(S(16'h0008, 1, 0)); sb.push_back(ov(1,0,0,2'b01,2'b01,0,0,2'b00,0,1));
        foreach (st[i]) begin
            drive(st[i]);
            @(negedge clk);
            e = sb.pop_front();
            checks++;
            if (obs !== e) begin errors++; $display("FAIL rst_mid cyc%0d got=%h exp=%h", i, obs, e); end
            if (i < 2) begin @(posedge clk); #1; end
        end
        // Still in the second PUSH_PC cycle with CALL held in decode.
        rst_n = 1'b0;
        sb.push_back(ZERO);
        #1;
        e = sb.pop_front();
        checks++;
        if (obs !== e) begin errors++; $display("FAIL rst_mid_async got=%h exp=%h", obs, e); end
        @(posedge clk); #1;
        drive(S(16'h0000, 0, 0));
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            sb.push_back(ZERO);
            @(negedge clk);
            e = sb.pop_front();
            checks++;
            if (obs !== e) begin errors++; $display("FAIL rst_after cyc%0d got=%h exp=%h", c, obs, e); end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        bus.ctrl_in     = 16'h0000;
        bus.instr_valid = 1'b0;
        bus.int_req     = 1'b0;
        rst_n           = 1'b0;
        @(posedge clk); #1;
        test_reset;
        test_call;
        test_rti;
        test_ext_jmp;
        test_int_during_ret;
        test_int_vs_call;
        test_reset_mid_call;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end
endmodule
